// File: rtl/frame_symbol_reader.sv
`default_nettype none
// ============================================================================
// frame_symbol_reader : drains the 513x1 handoff RAM into MSB-first symbols.
// Revision 1.0 - initial release
// ============================================================================
module frame_symbol_reader #(
  parameter int FRAME_BITS = 512,
  parameter int SYM_BITS   = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                En,
  output logic [9:0]          add_rom,
  input  logic                read_rom,
  output logic                web,
  output logic                write_rom,
  output logic [SYM_BITS-1:0] symbol,
  output logic                symbol_valid,
  input  logic                symbol_ready,
  output logic                frame_done
);

  localparam int SYMS   = FRAME_BITS / SYM_BITS;
  localparam int BIT_W  = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam int SYM_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int WAIT_W = $clog2(RD_LAT + 2);

  localparam logic [9:0]        FLAG_ADDR = 10'(FRAME_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SYM_BITS - 1);
  localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(SYMS - 1);
  localparam logic [WAIT_W-1:0] LAT       = WAIT_W'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL    = 3'd1,
    FETCH   = 3'd2,
    PRESENT = 3'd3,
    CLEAR   = 3'd4,
    SETTLE  = 3'd5
  } state_t;

  state_t              state;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SYM_W-1:0]    sym_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SYM_BITS-2:0] shreg;
  logic [SYM_BITS-1:0] next_bits;

  // Earlier (lower-address) bits shift toward the MSB.
  assign next_bits = {shreg, read_rom};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      add_rom      <= FLAG_ADDR;
      web          <= 1'b0;
      write_rom    <= 1'b0;
      symbol       <= '0;
      symbol_valid <= 1'b0;
      frame_done   <= 1'b0;
      bit_cnt      <= '0;
      sym_cnt      <= '0;
      wait_cnt     <= '0;
      shreg        <= '0;
    end else begin
      web        <= 1'b0;
      write_rom  <= 1'b0;
      frame_done <= 1'b0;
      // The flag write in CLEAR is never cut short; everything else aborts.
      if (!En && state != CLEAR) begin
        state        <= IDLE;
        add_rom      <= FLAG_ADDR;
        symbol_valid <= 1'b0;
        wait_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            add_rom  <= FLAG_ADDR;
            wait_cnt <= LAT;
            state    <= POLL;
          end
          POLL: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else if (read_rom) begin
              bit_cnt  <= '0;
              sym_cnt  <= '0;
              add_rom  <= '0;
              wait_cnt <= LAT;
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else begin
              shreg <= next_bits[SYM_BITS-2:0];
              if (bit_cnt == LAST_BIT) begin
                symbol       <= next_bits;
                symbol_valid <= 1'b1;
                state        <= PRESENT;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                add_rom  <= add_rom + 10'd1;
                wait_cnt <= LAT;
              end
            end
          end
          PRESENT: begin
            if (symbol_ready) begin
              symbol_valid <= 1'b0;
              if (sym_cnt == LAST_SYM) begin
                add_rom    <= FLAG_ADDR;
                web        <= 1'b1;
                frame_done <= 1'b1;
                state      <= CLEAR;
              end else begin
                sym_cnt  <= sym_cnt + 1'b1;
                bit_cnt  <= '0;
                add_rom  <= add_rom + 10'd1;
                wait_cnt <= LAT;
                state    <= FETCH;
              end
            end
          end
          CLEAR: begin
            // Hold off polling so the pre-write flag value is never seen.
            wait_cnt <= LAT;
            state    <= En ? SETTLE : IDLE;
          end
          SETTLE: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else begin
              wait_cnt <= LAT;
              state    <= POLL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
